seg_scan_arbiter: RTL and testbench

//  Scan controller and arbiter for the dual 4-digit seven-segment displays (D0 top, D1 bottom).
//  - Two requesters (e.g. switch echo, message source) each offer a 32-bit frame.
//  - Arbitrates between them at frame boundaries.
//  - Sequences the anode scan with an anti-ghosting blank gap and PWM brightness.
//  - Emits per-digit nibbles; the existing bto7s decoders (instanced at top level) convert them to segments.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_scan_arbiter_if.sv | 28 ++
 rtl/seg_rr_arb2.sv | 46 ++++
 rtl/seg_scan_arbiter.sv | 142 ++++++++++++++
 tb/tb_seg_scan_arbiter.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } seg_state_e;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low anode for digit idx: digit 0 drives bit 3, digit 3 drives bit 0.
  function automatic logic [3:0] an_onehot(input logic [1:0] idx);
    an_onehot = ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/seg_scan_arbiter_if.sv
// Requester/display bundle between the frame sources, the scan controller and the decoders.
interface seg_scan_arbiter_if;

  logic        REQ0;
  logic [31:0] FRAME0;
  logic        REQ1;
  logic [31:0] FRAME1;
  logic [3:0]  BRIGHT;
  logic        GNT0;
  logic        GNT1;
  logic        SRC;
  logic [3:0]  D0_AN;
  logic [3:0]  D1_AN;
  logic [3:0]  NIB0;
  logic [3:0]  NIB1;
  logic        FRAME_DONE;

  modport master (
    output REQ0, FRAME0, REQ1, FRAME1, BRIGHT,
    input  GNT0, GNT1, SRC, D0_AN, D1_AN, NIB0, NIB1, FRAME_DONE
  );

  modport slave (
    input  REQ0, FRAME0, REQ1, FRAME1, BRIGHT,
    output GNT0, GNT1, SRC, D0_AN, D1_AN, NIB0, NIB1, FRAME_DONE
  );

endinterface

// File: rtl/seg_rr_arb2.sv
// Two-way round-robin arbiter; grants are combinational and only valid while eval_i is high.
module seg_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       eval_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o     = 2'b00;
    gnt_idx_o = 1'b0;
    ptr_d     = ptr_q;
    if (eval_i) begin
      case (req_i)
        2'b01: begin
          gnt_o     = 2'b01;
          gnt_idx_o = 1'b0;
        end
        2'b10: begin
          gnt_o     = 2'b10;
          gnt_idx_o = 1'b1;
        end
        2'b11: begin
          // Pointer only moves on contention so a lone requester never shifts priority.
          gnt_o     = ptr_q ? 2'b10 : 2'b01;
          gnt_idx_o = ptr_q;
          ptr_d     = ~ptr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/seg_scan_arbiter.sv
// Dual 4-digit display scanner: blank-gap anode sequencing, PWM brightness and
// frame-boundary arbitration between two frame sources.
module seg_scan_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned DWELL_CYC = 500000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic               CLK_100MHZ,
  input  logic               RST_N,
  seg_scan_arbiter_if.slave  bus
);

  localparam int unsigned CntMax   = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int unsigned CntW     = $clog2(CntMax);
  localparam int unsigned SliceDiv = DWELL_CYC / 16;

  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYC - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0] SliceLen  = CntW'(SliceDiv);

  seg_state_e      state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [3:0]      bright_q, bright_d;
  logic [3:0]      an_q, an_d;
  logic [3:0]      nib0_q, nib0_d;
  logic [3:0]      nib1_q, nib1_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            done_q, done_d;
  logic            src_q, src_d;

  logic            boundary;
  logic [1:0]      arb_gnt;
  logic            arb_idx;
  logic [CntW-1:0] slice;

  assign boundary = (state_q == ST_ON) && (idx_q == 2'd3) && (cnt_q == DwellLast);

  seg_rr_arb2 u_arb (
    .clk_i     (CLK_100MHZ),
    .rst_ni    (RST_N),
    .req_i     ({bus.REQ1, bus.REQ0}),
    .eval_i    (boundary),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    bright_d = bright_q;
    nib0_d   = nib0_q;
    nib1_d   = nib1_q;
    src_d    = src_q;
    gnt_d    = arb_gnt;
    done_d   = boundary;
    an_d     = AN_OFF;

    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BlankLast) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_ON: begin
        if (cnt_q == DwellLast) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = boundary ? 2'd0 : idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase

    if (boundary) begin
      bright_d = bus.BRIGHT;
      if (arb_gnt != 2'b00) begin
        shadow_d = arb_idx ? bus.FRAME1 : bus.FRAME0;
        src_d    = arb_idx;
      end
    end

    // Nibbles are loaded as BLANK begins so the decoders settle before the anode lights.
    if (state_q == ST_ON && state_d == ST_BLANK) begin
      nib0_d = shadow_d[{1'b0, idx_d, 2'b00} +: 4];
      nib1_d = shadow_d[{1'b1, idx_d, 2'b00} +: 4];
    end

    // Outputs are computed from next state so the registered anodes line up with state_q.
    slice = cnt_d / SliceLen;
    if (state_d == ST_ON && slice <= CntW'(bright_d)) begin
      an_d = an_onehot(idx_d);
    end
  end

  always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_BLANK;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= 32'h0;
      bright_q <= 4'hF;
      an_q     <= AN_OFF;
      nib0_q   <= 4'h0;
      nib1_q   <= 4'h0;
      gnt_q    <= 2'b00;
      done_q   <= 1'b0;
      src_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      bright_q <= bright_d;
      an_q     <= an_d;
      nib0_q   <= nib0_d;
      nib1_q   <= nib1_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      src_q    <= src_d;
    end
  end

  assign bus.D0_AN      = an_q;
  assign bus.D1_AN      = an_q;
  assign bus.NIB0       = nib0_q;
  assign bus.NIB1       = nib1_q;
  assign bus.GNT0       = gnt_q[0];
  assign bus.GNT1       = gnt_q[1];
  assign bus.SRC        = src_q;
  assign bus.FRAME_DONE = done_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter with DWELL_CYC=32, BLANK_CYC=2 (136-cycle frame).
module tb_seg_scan_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seg_scan_arbiter_if bus_if ();

  seg_scan_arbiter #(
    .DWELL_CYC (32),
    .BLANK_CYC (2)
  ) dut (
    .CLK_100MHZ (clk),
    .RST_N      (rst_n),
    .bus        (bus_if)
  );

  int tests = 0;
  int fails = 0;
  int n     = 0;  // clock edges since the last reset release

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic go(input int tgt);
    while (n < tgt) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  initial begin
    bus_if.REQ0   = 1'b0;
    bus_if.REQ1   = 1'b0;
    bus_if.FRAME0 = 32'h0;
    bus_if.FRAME1 = 32'h0;
    bus_if.BRIGHT = 4'hF;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an0", bus_if.D0_AN, 4'hF);
    chk("rst_an1", bus_if.D1_AN, 4'hF);
    chk("rst_nib0", bus_if.NIB0, 4'h0);
    chk("rst_nib1", bus_if.NIB1, 4'h0);
    chk("rst_gnt", {bus_if.GNT1, bus_if.GNT0}, 2'b00);
    chk("rst_done", bus_if.FRAME_DONE, 1'b0);
    chk("rst_src", bus_if.SRC, 1'b0);

    // 1: idle scan
    rst_n = 1'b1;
    n     = 0;
    chk("scan_p0", bus_if.D0_AN, 4'hF);
    go(1);   chk("scan_p1", bus_if.D0_AN, 4'hF);
    go(2);   chk("scan_d0_on", bus_if.D0_AN, 4'b0111);
             chk("scan_d1an_eq", bus_if.D1_AN, 4'b0111);
    go(33);  chk("scan_d0_last", bus_if.D0_AN, 4'b0111);
    go(34);  chk("scan_blank1", bus_if.D0_AN, 4'hF);
    go(36);  chk("scan_d1_on", bus_if.D0_AN, 4'b1011);
    go(70);  chk("scan_d2_on", bus_if.D0_AN, 4'b1101);
    go(104); chk("scan_d3_on", bus_if.D1_AN, 4'b1110);
    go(135); chk("scan_done_early", bus_if.FRAME_DONE, 1'b0);
    go(136); chk("scan_done", bus_if.FRAME_DONE, 1'b1);
             chk("scan_bnd_an", bus_if.D0_AN, 4'hF);
             chk("scan_bnd_nib", {bus_if.NIB1, bus_if.NIB0}, 8'h00);
    go(137); chk("scan_done_pulse", bus_if.FRAME_DONE, 1'b0);

    // 2: single request
    bus_if.REQ0   = 1'b1;
    bus_if.FRAME0 = 32'hBEEF_1234;
    go(271); chk("g0_not_early", bus_if.GNT0, 1'b0);
    go(272); chk("g0_gnt", {bus_if.GNT1, bus_if.GNT0}, 2'b01);
             chk("g0_src", bus_if.SRC, 1'b0);
             chk("g0_nib_d0", {bus_if.NIB1, bus_if.NIB0}, 8'hF4);
    bus_if.REQ0 = 1'b0;
    go(273); chk("g0_pulse", bus_if.GNT0, 1'b0);
    go(306); chk("g0_nib_d1", {bus_if.NIB1, bus_if.NIB0}, 8'hE3);
    go(340); chk("g0_nib_d2", {bus_if.NIB1, bus_if.NIB0}, 8'hE2);
    go(374); chk("g0_nib_d3", {bus_if.NIB1, bus_if.NIB0}, 8'hB1);

    // 3: both requesting continuously
    bus_if.REQ0   = 1'b1;
    bus_if.FRAME0 = 32'h1111_2222;
    bus_if.REQ1   = 1'b1;
    bus_if.FRAME1 = 32'h5555_6666;
    go(408); chk("rr_1st", {bus_if.GNT1, bus_if.GNT0}, 2'b01);
             chk("rr_1st_src", bus_if.SRC, 1'b0);
             chk("rr_1st_nib", {bus_if.NIB1, bus_if.NIB0}, 8'h12);
    go(544); chk("rr_2nd", {bus_if.GNT1, bus_if.GNT0}, 2'b10);
             chk("rr_2nd_src", bus_if.SRC, 1'b1);
             chk("rr_2nd_nib", {bus_if.NIB1, bus_if.NIB0}, 8'h56);
    go(680); chk("rr_3rd", {bus_if.GNT1, bus_if.GNT0}, 2'b01);
             chk("rr_3rd_src", bus_if.SRC, 1'b0);
    bus_if.REQ0 = 1'b0;
    bus_if.REQ1 = 1'b0;

    // 4: brightness change mid-frame
    go(700); bus_if.BRIGHT = 4'd3;
    go(736); chk("pwm_cur_full", bus_if.D0_AN, 4'b1011);
    go(816); chk("pwm_bnd", bus_if.FRAME_DONE, 1'b1);
    go(818); chk("pwm_on_s0", bus_if.D0_AN, 4'b0111);
    go(825); chk("pwm_on_s3", bus_if.D0_AN, 4'b0111);
    go(826); chk("pwm_off_s4", bus_if.D0_AN, 4'hF);
    go(852); chk("pwm_d1_on", bus_if.D0_AN, 4'b1011);
    go(860); chk("pwm_d1_off", bus_if.D1_AN, 4'hF);

    // 5: withdrawn request
    bus_if.REQ1   = 1'b1;
    bus_if.FRAME1 = 32'hDEAD_BEEF;
    go(900); bus_if.REQ1 = 1'b0;
    go(952); chk("wd_gnt", {bus_if.GNT1, bus_if.GNT0}, 2'b00);
             chk("wd_done", bus_if.FRAME_DONE, 1'b1);
             chk("wd_src", bus_if.SRC, 1'b0);
             chk("wd_nib", {bus_if.NIB1, bus_if.NIB0}, 8'h12);

    // 6: reset during digit 2 ON
    go(1024); chk("mr_pre_an", bus_if.D0_AN, 4'b1101);
    rst_n = 1'b0;
    #1;
    chk("mr_an_async", {bus_if.D1_AN, bus_if.D0_AN}, 8'hFF);
    chk("mr_nib_async", {bus_if.NIB1, bus_if.NIB0}, 8'h00);
    #2;
    rst_n = 1'b1;
    n     = 0;
    go(1);   chk("mr_blank", bus_if.D0_AN, 4'hF);
    go(2);   chk("mr_d0_on", bus_if.D0_AN, 4'b0111);
    go(20);  chk("mr_bright_rst", bus_if.D0_AN, 4'b0111);
    go(34);  chk("mr_shadow_clr", {bus_if.NIB1, bus_if.NIB0}, 8'h00);
    go(136); chk("mr_bnd_done", bus_if.FRAME_DONE, 1'b1);
             chk("mr_bnd_gnt", {bus_if.GNT1, bus_if.GNT0}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
